// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and byte-lane merge for the data-memory responder
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old, input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
    merge_lanes = old;
    for (int i = 0; i < BE_W; i++)
      if (be[i]) merge_lanes[8*i +: 8] = wdata[8*i +: 8];
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word-organised byte-lane RAM, synchronous read-before-write on the same edge
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [BE_W-1:0]                be,
  input  logic [DATA_W-1:0]              wdata,
  output logic [DATA_W-1:0]              rdata
);
  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en) mem[idx] <= merge_lanes(mem[idx], wdata, be);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else if (en) rdata <= clr ? '0 : mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store slave with WAIT_STATES latency; DMEM_RANGE_CHECK_EN adds mem_err_out
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  input  logic [BE_W-1:0]   mem_write_byte_en_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_valid_out
`ifdef DMEM_RANGE_CHECK_EN
  , output logic            mem_err_out
`endif
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_nx;
  logic [3:0] cnt_q, cnt_nx;
  logic [AW-1:0] idx_q, idx_use;
  logic [DATA_W-1:0] wdata_q, wdata_use;
  logic [BE_W-1:0] be_q, be_use;
  logic oor_q, oor_in, oor_use, accept, fire;
  logic unused_addr;
  assign unused_addr = ^mem_addr_in;
`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
  assign oor_in = {1'b0, mem_addr_in} >= LIMIT;
  assign mem_err_out = state == RESP && oor_q;
`else
  assign oor_in = 1'b0;
`endif
  assign accept = state == IDLE && mem_req_in;
  // with zero wait states the accepting edge is also the RESP-entry edge, so use live inputs
  assign idx_use = state == IDLE ? mem_addr_in[AW+1:2] : idx_q;
  assign wdata_use = state == IDLE ? mem_wdata_in : wdata_q;
  assign be_use = state == IDLE ? mem_write_byte_en_in : be_q;
  assign oor_use = state == IDLE ? oor_in : oor_q;
  assign fire = state_nx == RESP;
  assign mem_valid_out = state == RESP;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt_q;
    if (accept) begin
      state_nx = WAIT_STATES == 0 ? RESP : WAIT;
      cnt_nx = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
    end else if (state == WAIT) begin
      state_nx = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_nx = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state == RESP) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      oor_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      if (accept) begin
        idx_q <= mem_addr_in[AW+1:2];
        wdata_q <= mem_wdata_in;
        be_q <= mem_write_byte_en_in;
        oor_q <= oor_in;
      end
    end
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (fire),
    .clr   (oor_use),
    .idx   (idx_use),
    .be    (oor_use ? '0 : be_use),
    .wdata (wdata_use),
    .rdata (mem_rdata_out)
  );
endmodule
